cla_wide_seq: RTL

Multi-pass sequencer that performs wide (NWORDS×W-bit) additions by time-sharing a single W-bit carry-lookahead adder. It sits between the 512-bit MAC accumulator logic and one 128-bit CLA instance: it accepts a full-width operand pair over a valid/ready handshake and feeds the adder one W-bit slice per cycle, LSW first, chaining the carry through a register. It returns the full-width sum plus the final carry-out over a second valid/ready handshake.

---
 rtl/cla_wide_seq.sv | 121 ++++++++++++
 1 files changed

// File: rtl/cla_wide_seq.sv
// cla_wide_seq: wide adder that runs NWORDS passes through one external W-bit CLA.
// The operands are captured on accept. Slices are fed to the adder LSW first, and
// the carry is chained through a register. The result is held until the consumer
// takes it.
// Optional feature macro: CLA_WIDE_SEQ_SUB_EN. It adds sub_in and computes A - B
// as A + ~B + 1.
module cla_wide_seq #(
    parameter  int W      = 128,
    parameter  int NWORDS = 4,
    localparam int N      = W * NWORDS
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] a_in,
    input  logic [N-1:0] b_in,
    input  logic         ci_in,
`ifdef CLA_WIDE_SEQ_SUB_EN
    input  logic         sub_in,
`endif
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] sum_out,
    output logic         cout_out,
    output logic         busy,
    output logic [W-1:0] add_a,
    output logic [W-1:0] add_b,
    output logic         add_ci,
    input  logic [W-1:0] add_s,
    input  logic         add_co
);

    localparam int          KW    = (NWORDS > 1) ? $clog2(NWORDS) : 1;
    localparam logic [KW-1:0] KLAST = KW'(NWORDS - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

    state_e                      state_q;
    logic [NWORDS-1:0][W-1:0]    a_q, b_q;
    logic [NWORDS-1:0][W-1:0]    sum_q;
    logic                        carry_q;
    logic                        cout_q;
    logic [KW-1:0]               k_q;
    logic                        run;

    // Operand conditioning on accept. Subtract folds into add by inverting B and forcing carry-in.
    logic [N-1:0] b_cap_d;
    logic         ci_cap_d;
`ifdef CLA_WIDE_SEQ_SUB_EN
    assign b_cap_d  = sub_in ? ~b_in : b_in;
    assign ci_cap_d = sub_in ? 1'b1  : ci_in;
`else
    assign b_cap_d  = b_in;
    assign ci_cap_d = ci_in;
`endif

    assign run = (state_q == RUN);

    // Sequencer: accept, step the beat counter and chain the carry, then hold the result for the handshake
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            k_q     <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        a_q     <= a_in;
                        b_q     <= b_cap_d;
                        carry_q <= ci_cap_d;
                        k_q     <= '0;
                        state_q <= RUN;
                    end
                end
                RUN: begin
                    carry_q <= add_co;
                    if (k_q == KLAST) begin
                        cout_q  <= add_co;
                        k_q     <= '0;
                        state_q <= DONE;
                    end else begin
                        k_q <= k_q + KW'(1);
                    end
                end
                DONE: begin
                    if (out_ready) state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Per-slice result capture. Each slice loads only on its own beat, so the others hold.
    for (genvar j = 0; j < NWORDS; j++) begin : g_slice
        logic we;
        assign we = run && (k_q == KW'(j));

        // Writeback of adder sum into slice j
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n)  sum_q[j] <= '0;
            else if (we) sum_q[j] <= add_s;
        end
    end

    // Adder feed is quiet outside RUN so the shared CLA sees zeros when unused
    assign add_a  = run ? a_q[k_q] : '0;
    assign add_b  = run ? b_q[k_q] : '0;
    assign add_ci = run ? carry_q  : 1'b0;

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q != IDLE);
    assign sum_out   = sum_q;
    assign cout_out  = cout_q;

endmodule
